// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants: arctangent table in turns, 1/K gain, state encoding.
package cordic_pkg;

  localparam int K_INV_Q15 = 19898;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_GAIN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // atan(2^-k) / (2*pi), in turns, Q0.32
  localparam logic [31:0] ATAN_Q32 [16] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  function automatic logic [31:0] atan_scaled(input logic [3:0] k, input int zw);
    logic [32:0] acc;
    acc = {1'b0, ATAN_Q32[k]} + (33'd1 << (31 - zw));
    return 32'(acc >> (32 - zw));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational iteration index to arctangent at Z accumulator width.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ZW = 17
) (
  input  logic [3:0]    k,
  output logic [ZW-1:0] atan
);

  logic [ZW-1:0] rom_q [16];

  for (genvar i = 0; i < 16; i++) begin : g_rom
    assign rom_q[i] = ZW'(atan_scaled(4'(i), ZW));
  end

  assign atan = rom_q[k];

endmodule

// File: rtl/iq_phase_cordic.sv
// rtl/iq_phase_cordic.sv - iterative vectoring CORDIC, I/Q to phase (turns) and magnitude.
// Optional gain compensation state enabled by `CORDIC_GAIN_COMP_EN.
module iq_phase_cordic
  import cordic_pkg::*;
#(
  parameter int I_WIDTH = 12,
  parameter int O_WIDTH = 13,
  parameter int ITER    = 12,
  parameter int GUARD   = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic signed [I_WIDTH-1:0] i_x,
  input  logic signed [I_WIDTH-1:0] i_y,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [O_WIDTH-1:0]        o_phase,
  output logic [I_WIDTH:0]          o_mag
);

  localparam int W       = I_WIDTH + 2 + GUARD;
  localparam int ZW      = O_WIDTH + 4;
  localparam int MAG_MAX = 2**(I_WIDTH+1) - 1;
  localparam logic signed [W-1:0] MAG_MAX_W = W'(MAG_MAX);
  localparam logic [ZW-1:0]       Z_HALF    = ZW'(1) << (ZW - 1);
  localparam logic [ZW-1:0]       Z_RND     = ZW'(1) << (ZW - O_WIDTH - 1);

  state_t                state;
  logic signed [W-1:0]   x_q, y_q, x_nxt, y_nxt;
  logic [ZW-1:0]         z_q, z_nxt, atan;
  logic [3:0]            k_q;
  logic                  zero_q;
  logic signed [W-1:0]   x_ext, y_ext;

  assign x_ext = {{(W-I_WIDTH-GUARD){i_x[I_WIDTH-1]}}, i_x, {GUARD{1'b0}}};
  assign y_ext = {{(W-I_WIDTH-GUARD){i_y[I_WIDTH-1]}}, i_y, {GUARD{1'b0}}};

  cordic_atan_rom #(.ZW(ZW)) u_rom (.k(k_q), .atan(atan));

  // Rotate toward the +x axis; both updates use the pre-rotation X and Y.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    z_nxt = z_q;
    if (!y_q[W-1]) begin
      x_nxt = x_q + (y_q >>> k_q);
      y_nxt = y_q - (x_q >>> k_q);
      z_nxt = z_q + atan;
    end else begin
      x_nxt = x_q - (y_q >>> k_q);
      y_nxt = y_q + (x_q >>> k_q);
      z_nxt = z_q - atan;
    end
  end

  function automatic logic [O_WIDTH-1:0] phase_of(input logic [ZW-1:0] z);
    return O_WIDTH'((z + Z_RND) >> (ZW - O_WIDTH));
  endfunction

  function automatic logic [I_WIDTH:0] mag_sat(input logic signed [W-1:0] xv);
    logic signed [W-1:0] t;
    t = xv >>> GUARD;
    if (t < 0)              return '0;
    else if (t > MAG_MAX_W) return (I_WIDTH+1)'(MAG_MAX);
    else                    return t[I_WIDTH:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = W + 16;
  localparam logic signed [PW-1:0] K_P   = PW'(K_INV_Q15);
  localparam logic signed [PW-1:0] RND_P = PW'(1) << 14;
  logic signed [W-1:0] x_gain;
  assign x_gain = W'((PW'(x_q) * K_P + RND_P) >>> 15);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_phase <= '0;
      o_mag   <= '0;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_valid) begin
          o_ready <= 1'b0;
          zero_q  <= (i_x == '0) && (i_y == '0);
          k_q     <= '0;
          state   <= ST_ROT;
          if (i_x[I_WIDTH-1]) begin
            x_q <= -x_ext;
            y_q <= -y_ext;
            z_q <= Z_HALF;
          end else begin
            x_q <= x_ext;
            y_q <= y_ext;
            z_q <= '0;
          end
        end
        ST_ROT: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          k_q <= k_q + 4'd1;
          if (k_q == 4'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
            state   <= ST_GAIN;
`else
            state   <= ST_DONE;
            o_valid <= 1'b1;
            o_phase <= zero_q ? '0 : phase_of(z_nxt);
            o_mag   <= zero_q ? '0 : mag_sat(x_nxt);
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          state   <= ST_DONE;
          o_valid <= 1'b1;
          o_phase <= zero_q ? '0 : phase_of(z_q);
          o_mag   <= zero_q ? '0 : mag_sat(x_gain);
        end
`endif
        ST_DONE: if (i_ready) begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_phase_cordic.sv
// tb/tb_iq_phase_cordic.sv - scoreboard bench for iq_phase_cordic (honours `CORDIC_GAIN_COMP_EN).
module tb_iq_phase_cordic;

  localparam int ITER = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
  localparam int M2047 = 2047, M2048 = 2048, M1448 = 2047, MT = 3;
`else
  localparam int LAT = ITER + 1;
  localparam int M2047 = 3371, M2048 = 3372, M1448 = 3372, MT = 4;
`endif

  typedef struct {int ph; int ptol; int mag; int mtol;} exp_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [11:0] x = '0, y = '0;
  logic        dut_ready, dut_valid;
  logic [12:0] phase;
  logic [12:0] mag;
  exp_t        sb[$];
  int          errors = 0, checks = 0;

  iq_phase_cordic #(.I_WIDTH(12), .O_WIDTH(13), .ITER(ITER), .GUARD(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(dut_ready),
    .i_x(x), .i_y(y), .o_valid(dut_valid), .i_ready(out_ready),
    .o_phase(phase), .o_mag(mag)
  );

  always #5 clk = ~clk;

  function automatic int phase_err(input int a, input int e);
    int d;
    d = (a - e) & 8191;
    if (d >= 4096) d -= 8192;
    return (d < 0) ? -d : d;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a result is transferred whenever valid and ready meet.
  initial forever begin
    @(negedge clk);
    if (dut_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: phase %0d mag %0d with empty scoreboard", phase, mag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (phase_err(int'(phase), e.ph) > e.ptol) begin
          errors++;
          $display("FAIL phase: got %0d, expected %0d +-%0d", phase, e.ph, e.ptol);
        end
        checks++;
        if ((int'(mag) > e.mag + e.mtol) || (int'(mag) < e.mag - e.mtol)) begin
          errors++;
          $display("FAIL mag: got %0d, expected %0d +-%0d", mag, e.mag, e.mtol);
        end
      end
    end
  end

  // Issue one sample, queue its expectation, and measure accept-to-valid latency.
  task automatic issue(input int xi, input int yi, input int ph, input int ptol,
                       input int mg, input int mtol);
    int n;
    exp_t e;
    @(posedge clk); #1;
    check("ready_before_issue", int'(dut_ready), 1);
    e.ph = ph; e.ptol = ptol; e.mag = mg; e.mtol = mtol;
    sb.push_back(e);
    in_valid = 1'b1; x = 12'(xi); y = 12'(yi);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!dut_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LAT);
  endtask

  initial begin
    int n, diffs, ref_ph, ref_mag;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(dut_ready), 1);
    check("reset_valid", int'(dut_valid), 0);
    check("reset_phase", int'(phase), 0);
    check("reset_mag", int'(mag), 0);
    rst = 1'b0;

    issue(2047, 0, 0, 2, M2047, MT);
    issue(0, 2047, 2048, 2, M2047, MT);
    issue(-2047, 0, 4096, 2, M2047, MT);
    issue(0, -2047, 6144, 2, M2047, MT);
    issue(-2048, 0, 4096, 2, M2048, MT);
    issue(1448, 1448, 1024, 2, M1448, MT);
    issue(0, 0, 0, 0, 0, 0);
    issue(0, 2047, 2048, 2, M2047, MT);

    // Abort mid-rotation: result must be lost and outputs cleared.
    @(posedge clk); #1;
    in_valid = 1'b1; x = 12'sd1000; y = 12'sd500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", int'(dut_valid), 0);
    check("abort_phase", int'(phase), 0);
    check("abort_mag", int'(mag), 0);
    check("abort_ready", int'(dut_ready), 1);

    // Backpressure: hold result for 20 cycles while extra samples are offered.
    out_ready = 1'b0;
    issue(1448, 1448, 1024, 2, M1448, MT);
    diffs = 0; ref_ph = int'(phase); ref_mag = int'(mag);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", int'(dut_valid), 1);
      check("bp_ready", int'(dut_ready), 0);
      checks++;
      if (phase_err(int'(phase), 1024) > 2) begin
        errors++;
        $display("FAIL bp_phase: got %0d, expected 1024 +-2", phase);
      end
      if (int'(phase) != ref_ph || int'(mag) != ref_mag) diffs++;
      in_valid = 1'b1; x = -12'sd1000; y = 12'sd300;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_output_changes", diffs, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", int'(dut_valid), 0);
    check("release_ready", int'(dut_ready), 1);
    repeat (ITER + 5) @(posedge clk);

    // Round trip against ideal quarter-wave LUT samples of amplitude 2047.
    for (int p = 0; p < 8192; p += 7) begin
      real a;
      a = 2.0 * 3.14159265358979 * real'(p) / 8192.0;
      issue(int'(2047.0 * $cos(a)), int'(2047.0 * $sin(a)), p, 2, M2047, MT + 2);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
